// File: rtl/bios_burst_sink.sv
// bios_burst_sink: consumer end of the BIOS download handshake.
// Pulls fixed-length bursts from the producer with bios_req and buffers them in a
// show-ahead FIFO. The FIFO is drained to a memory write port using req/ready.
// Handshake on the memory side: a word transfers on every rising edge where
// mem_req & mem_ready; while mem_req is high and mem_ready is low, mem_addr
// and mem_data hold their values.
module bios_burst_sink #(
   parameter int                BURST_LEN  = 32,
   parameter int                FIFO_DEPTH = 64,
   parameter int                MEM_AW     = 21,
   parameter logic [MEM_AW-1:0] BASE_ADDR  = MEM_AW'('h0F8000),
   parameter int                CNT_W      = 13
) (
   input  logic              clk_sdr,
   input  logic              rst_n,
   input  logic              start,
   input  logic              bios_wr,
   output logic              bios_req,
   input  logic [15:0]       bios_din,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN);
   localparam int SW = (MEM_AW > CNT_W) ? MEM_AW : CNT_W;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [PW:0]   FULL_OCC  = (PW + 1)'(FIFO_DEPTH);
   // Largest occupancy that still leaves room for a whole burst.
   localparam logic [PW:0]   FREE_LIM  = (PW + 1)'(FIFO_DEPTH - BURST_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BW-1:0]      r_beat;
   logic [BW-1:0]      w_beat_nxt;
   logic               r_hold;
   logic               w_hold_nxt;
   logic               r_req_d;
   logic               r_start_pend;
   logic [PW:0]        r_wr_ptr;
   logic [PW:0]        r_rd_ptr;
   logic [CNT_W-1:0]   r_word_count;
   logic [15:0]        r_fifo [FIFO_DEPTH];

   logic [PW:0]        w_occ;
   logic               w_empty;
   logic               w_full;
   logic               w_space_ok;
   logic               w_flush;
   logic               w_push;
   logic               w_pop;
   logic [SW-1:0]      w_addr_sum;

   assign w_occ      = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (w_occ == '0);
   assign w_full     = (w_occ == FULL_OCC);
   assign w_space_ok = (w_occ <= FREE_LIM);

   // A start seen outside IDLE is parked and applied on the first IDLE cycle,
   // so a burst in flight always completes before its data is thrown away.
   assign w_flush = (r_state == S_IDLE) && (start || r_start_pend);
   // Capture lags the pull strobe by one cycle: bios_din answers last cycle's bios_req.
   assign w_push  = r_req_d;
   // A start in the same cycle as an accept wins; the accepted word is discarded.
   assign w_pop   = mem_req && mem_ready && !w_flush;

   // Pull FSM state, beat and hold counters
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Pull FSM next state: IDLE -> REQ (BURST_LEN beats) -> HOLD (2 cycles) -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_hold_nxt  = r_hold;
      case (r_state)
         S_IDLE: begin
            if (bios_wr && w_space_ok) begin
               w_state_nxt = S_REQ;
               w_beat_nxt  = '0;
            end
         end
         S_REQ: begin
            if (r_beat == LAST_BEAT) begin
               w_state_nxt = S_HOLD;
               w_hold_nxt  = 1'b0;
            end else begin
               w_beat_nxt = r_beat + 1'b1;
            end
         end
         S_HOLD: begin
            // bios_wr is deliberately ignored here so the producer can drop it.
            if (r_hold) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_hold_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Delayed pull strobe and parked start request
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) begin
         r_req_d      <= 1'b0;
         r_start_pend <= 1'b0;
      end else begin
         r_req_d <= bios_req;
         if (w_flush) begin
            r_start_pend <= 1'b0;
         end else if (start && (r_state != S_IDLE)) begin
            r_start_pend <= 1'b1;
         end
      end
   end

   // FIFO read/write pointers (one extra bit distinguishes full from empty)
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers qualify them
   always_ff @(posedge clk_sdr) begin
      if (w_push && !w_flush) begin
         r_fifo[r_wr_ptr[PW-1:0]] <= bios_din;
      end
   end

   // Count of words accepted by memory since the last start
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) begin
         r_word_count <= '0;
      end else if (w_flush) begin
         r_word_count <= '0;
      end else if (w_pop) begin
         r_word_count <= r_word_count + 1'b1;
      end
   end

   assign w_addr_sum = SW'(BASE_ADDR) + SW'(r_word_count);

   assign bios_req   = (r_state == S_REQ);
   assign mem_req    = !w_empty;
   assign mem_data   = w_empty ? 16'h0000 : r_fifo[r_rd_ptr[PW-1:0]];
   assign mem_addr   = w_addr_sum[MEM_AW-1:0];
   assign word_count = r_word_count;
   assign busy       = (r_state != S_IDLE) || !w_empty || r_start_pend;
   assign dbg_state  = r_state;

   // The free-space check in IDLE must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk_sdr) disable iff (!rst_n)
      !(w_push && w_full && !w_pop));

endmodule
